// File: rtl/imem_fetch_seq_if.sv
// Bus between the fetch sequencer, the instruction memory and the decode stage.
// The master side is the fetch sequencer; the slave side is its environment
// (IMem read port, decode handshake, run/jump control).
interface imem_fetch_seq_if;
    logic        run;
    logic [15:0] im_addr;
    logic [7:0]  im_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        jmp_en;
    logic [15:0] jmp_addr;
    logic        halted;

    modport master (
        input  run, im_data, instr_ready, jmp_en, jmp_addr,
        output im_addr, instr_valid, instr_op, instr_operand, instr_pc, halted
    );

    modport slave (
        output run, im_data, instr_ready, jmp_en, jmp_addr,
        input  im_addr, instr_valid, instr_op, instr_operand, instr_pc, halted
    );
endinterface

// File: rtl/imem_fetch_seq.sv
// Instruction fetch sequencer: walks the byte-wide IMem one byte per clock,
// assembles opcode plus 0..2 operand bytes and hands the result to decode
// over a valid/ready handshake. Supports jump redirects, halt and 16-bit
// PC wrap-around.
module imem_fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  HALT_OP  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_OPR1,
        S_OPR2,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_op;
    logic [15:0] r_operand;
    logic [15:0] r_instr_pc;
    logic        r_valid;
    logic        r_halted;

    logic [15:0] w_pc_inc;
    logic [1:0]  w_len_in;
    logic [1:0]  w_len_op;
    logic        w_handshake;

    // Operand byte count encoded in the opcode's upper nibble.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op[7:4])
            4'b0000, 4'b0101: op_len = 2'd2;
            4'b1000, 4'b1001: op_len = 2'd1;
            default:          op_len = 2'd0;
        endcase
    endfunction

    // PC increments wrap naturally at 16 bits (FFFF -> 0000).
    assign w_pc_inc    = r_pc + 16'd1;
    assign w_len_in    = op_len(bus.im_data);
    assign w_len_op    = op_len(r_op);
    assign w_handshake = r_valid & bus.instr_ready;

    assign bus.im_addr       = r_pc;
    assign bus.instr_valid   = r_valid;
    assign bus.instr_op      = r_op;
    assign bus.instr_operand = r_operand;
    assign bus.instr_pc      = r_instr_pc;
    assign bus.halted        = r_halted;

    // Fetch FSM: jumps override everything but reset and discard any partial
    // or pending instruction (a handshake in the same cycle still completes).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_op       <= 8'h00;
            r_operand  <= 16'h0000;
            r_instr_pc <= 16'h0000;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else if (bus.jmp_en) begin
            r_pc     <= bus.jmp_addr;
            r_state  <= S_OP;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    r_op       <= bus.im_data;
                    r_instr_pc <= r_pc;
                    r_operand  <= 16'h0000;
                    r_pc       <= w_pc_inc;
                    if (w_len_in == 2'd0) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_OPR1;
                    end
                end
                S_OPR1: begin
                    r_pc <= w_pc_inc;
                    if (w_len_op == 2'd2) begin
                        r_operand <= {bus.im_data, 8'h00};
                        r_state   <= S_OPR2;
                    end else begin
                        r_operand <= {8'h00, bus.im_data};
                        r_state   <= S_HOLD;
                        r_valid   <= 1'b1;
                    end
                end
                S_OPR2: begin
                    r_operand[7:0] <= bus.im_data;
                    r_pc           <= w_pc_inc;
                    r_state        <= S_HOLD;
                    r_valid        <= 1'b1;
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_op == HALT_OP) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else if (bus.run) begin
                            r_state <= S_OP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_seq.sv
// Scoreboard bench for imem_fetch_seq: a byte-array IMem, an instruction-level
// reference model that walks programs and queues the expected words, and a
// monitor that checks every delivered instruction.
module tb_imem_fetch_seq;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] operand;
        logic [15:0] pc;
        logic [15:0] addr;
        int          gap;
    } exp_t;

    logic clk;
    logic rst;
    imem_fetch_seq_if bus();

    logic [7:0] mem [0:65535];
    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         hs_count = 0;
    int         last_hs = 0;

    imem_fetch_seq #(
        .RESET_PC(16'hFFFF),
        .HALT_OP (8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.im_data = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Operand length table straight from the instruction set definition.
    function automatic int model_len(input logic [7:0] op);
        if (op[7:4] == 4'h0 || op[7:4] == 4'h5) return 2;
        if (op[7:4] == 4'h8 || op[7:4] == 4'h9) return 1;
        return 0;
    endfunction

    // Walk a program from start until the halt opcode, queueing each word.
    task automatic walk(input logic [15:0] start, input bit gaps, input int first_gap);
        logic [15:0] pc;
        exp_t        e;
        int          len;
        pc = start;
        for (int i = 0; i < 200; i++) begin
            e.op      = mem[pc];
            len       = model_len(e.op);
            e.pc      = pc;
            e.operand = (len == 2) ? {mem[pc + 16'd1], mem[pc + 16'd2]} :
                        (len == 1) ? {8'h00, mem[pc + 16'd1]} : 16'h0000;
            e.addr    = pc + 16'(1 + len);
            e.gap     = (i == 0) ? first_gap : (gaps ? len + 2 : -1);
            exp_q.push_back(e);
            pc = e.addr;
            if (e.op == 8'hFF) break;
        end
    endtask

    // Random program of n non-halt instructions followed by a halt opcode.
    task automatic gen_prog(input logic [15:0] start, input int n);
        logic [15:0] pc;
        logic [7:0]  op;
        pc = start;
        for (int i = 0; i < n; i++) begin
            op = 8'($urandom_range(0, 254));
            mem[pc] = op;
            for (int k = 1; k <= model_len(op); k++) mem[pc + 16'(k)] = 8'($urandom_range(0, 255));
            pc = pc + 16'(1 + model_len(op));
        end
        mem[pc] = 8'hFF;
    endtask

    task automatic push1(input logic [7:0] op, input logic [15:0] opr,
                         input logic [15:0] pc, input logic [15:0] addr, input int gap);
        exp_t e;
        e.op = op; e.operand = opr; e.pc = pc; e.addr = addr; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.instr_valid && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 32'(bus.instr_valid), 1);
    endtask

    task automatic wait_drain(input string nm, input bit rnd_ready, input bit want_halt);
        int n = 0;
        bit done;
        done = 1'b0;
        while (n < 3000) begin
            done = (exp_q.size() == 0) && (want_halt ? bus.halted : !bus.instr_valid);
            if (done) break;
            if (rnd_ready) bus.instr_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk(nm, 32'(done), 1);
    endtask

    task automatic jump(input logic [15:0] a);
        bus.jmp_en   = 1'b1;
        bus.jmp_addr = a;
        tick();
        bus.jmp_en   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},   32'(bus.instr_valid), 0);
        chk({tag, "_op"},      32'(bus.instr_op), 0);
        chk({tag, "_operand"}, 32'(bus.instr_operand), 0);
        chk({tag, "_pc"},      32'(bus.instr_pc), 0);
        chk({tag, "_halted"},  32'(bus.halted), 0);
        chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'h0000FFFF);
    endtask

    // Monitor: every handshake must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.instr_valid && bus.instr_ready) begin
                hs_count++;
                chk("hs_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("op",      32'(bus.instr_op), 32'(e.op));
                    chk("operand", 32'(bus.instr_operand), 32'(e.operand));
                    chk("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
                    chk("im_addr_at_valid", 32'(bus.im_addr), 32'(e.addr));
                    if (e.gap >= 0) chk("throughput_gap", 32'(cyc - last_hs), 32'(e.gap));
                end
                last_hs = cyc;
            end
        end
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h21;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jmp_en = 1'b0;
        bus.jmp_addr = 16'h0000;
        repeat (3) tick();
        chk_reset_vals("reset");

        // Wrapping operand, then a short mixed program ending in halt.
        mem[16'hFFFF] = 8'h5F; mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02;
        mem[16'h0002] = 8'h0F; mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h05;
        mem[16'h0005] = 8'h8F; mem[16'h0006] = 8'h03;
        mem[16'h0007] = 8'h21;
        mem[16'h0008] = 8'h9A; mem[16'h0009] = 8'h7E;
        mem[16'h000A] = 8'hFF;
        walk(16'hFFFF, 1'b1, -1);
        rst = 1'b0;
        bus.run = 1'b1;
        bus.instr_ready = 1'b1;
        wait_drain("drain_basic", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_addr_frozen", 32'(bus.im_addr), 32'h000B);
            chk("halt_valid_low", 32'(bus.instr_valid), 0);
            chk("halt_flag", 32'(bus.halted), 1);
        end

        // Random program with random ready, entered by a jump out of HALT.
        gen_prog(16'h1000, 40);
        walk(16'h1000, 1'b0, -1);
        jump(16'h1000);
        chk("halt_cleared_by_jump", 32'(bus.halted), 0);
        wait_drain("drain_random", 1'b1, 1'b1);

        // Back-pressure: fields stable, then exactly one handshake.
        mem[16'h2000] = 8'h92; mem[16'h2001] = 8'h44; mem[16'h2002] = 8'h30;
        push1(8'h92, 16'h0044, 16'h2000, 16'h2002, -1);
        bus.run = 1'b0;
        bus.instr_ready = 1'b0;
        jump(16'h2000);
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            chk("stall_op", 32'(bus.instr_op), 32'h92);
            chk("stall_operand", 32'(bus.instr_operand), 32'h0044);
            chk("stall_pc", 32'(bus.instr_pc), 32'h2000);
            chk("stall_im_addr", 32'(bus.im_addr), 32'h2002);
            chk("stall_valid_held", 32'(bus.instr_valid), 1);
            tick();
        end
        begin
            int hs0;
            hs0 = hs_count;
            bus.instr_ready = 1'b1;
            tick();
            bus.instr_ready = 1'b0;
            repeat (3) tick();
            chk("single_handshake", 32'(hs_count - hs0), 1);
            chk("idle_after_run_low", 32'(bus.instr_valid), 0);
            chk("idle_addr", 32'(bus.im_addr), 32'h2002);
        end

        // Jump during operand fetch drops the partial instruction.
        mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'hAA; mem[16'h0012] = 8'hBB;
        mem[16'h0102] = 8'h85; mem[16'h0103] = 8'h33;
        push1(8'h85, 16'h0033, 16'h0102, 16'h0104, -1);
        bus.instr_ready = 1'b1;
        jump(16'h0010);
        tick();
        jump(16'h0102);
        chk("redirect_addr", 32'(bus.im_addr), 32'h0102);
        wait_drain("drain_redirect", 1'b0, 1'b0);

        // Jump together with the handshake of a halt opcode: jump wins.
        mem[16'h3000] = 8'hFF; mem[16'h3100] = 8'h21; mem[16'h3101] = 8'hFF;
        push1(8'hFF, 16'h0000, 16'h3000, 16'h3001, -1);
        walk(16'h3100, 1'b1, 2);
        bus.run = 1'b1;
        bus.instr_ready = 1'b0;
        jump(16'h3000);
        wait_valid("halt_op_valid");
        bus.instr_ready = 1'b1;
        jump(16'h3100);
        chk("jump_beats_halt", 32'(bus.halted), 0);
        chk("jump_beats_halt_addr", 32'(bus.im_addr), 32'h3100);
        wait_drain("drain_jump_hs", 1'b0, 1'b1);

        // Reset while holding an instruction.
        mem[16'h4000] = 8'h21;
        bus.instr_ready = 1'b0;
        jump(16'h4000);
        wait_valid("pre_reset_valid");
        rst = 1'b1;
        tick();
        chk_reset_vals("mid_hold_reset");
        rst = 1'b0;
        bus.run = 1'b0;
        tick();
        chk("queue_empty_end", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
